// File: rtl/pwm_timer_pkg.sv
// pwm_timer_pkg: shared types and defaults
// for the multi-channel PWM/interval timer
package pwm_timer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } ch_state_e;

  typedef enum logic {
    CONT    = 1'b0,
    ONESHOT = 1'b1
  } ch_mode_e;

  localparam int NUM_CH_DEF  = 4;
  localparam int CNT_W_DEF   = 16;
  localparam int PRESC_W_DEF = 8;

endpackage

// File: rtl/pwm_timer_ch.sv
// pwm_timer_ch: one timer channel
// FSM, counter, shadowed period/duty
module pwm_timer_ch
  import pwm_timer_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             ce,
  input  logic             ch_en,
  input  logic             mode,
  input  logic             start,
  input  logic             cfg_wr,
  input  logic [CNT_W-1:0] period,
  input  logic [CNT_W-1:0] duty,
  output logic             pulse,
  output logic             tick,
  output logic             busy
);

  ch_state_e        state;
  ch_state_e        state_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic [CNT_W-1:0] act_p;
  logic [CNT_W-1:0] act_d;
  logic [CNT_W-1:0] pend_p;
  logic [CNT_W-1:0] pend_d;
  logic             pend_valid;
  logic [CNT_W-1:0] last;
  logic             run;
  logic             wrap;
  logic             load;
  logic             oneshot;

  assign run     = (state == RUN);
  assign oneshot = (ch_mode_e'(mode) == ONESHOT);
  // period 0 behaves as period 1
  assign last = (act_p == '0) ? '0
              : act_p - CNT_W'(1);
  assign wrap = run && ce && (cnt == last);
  assign load = pend_valid && (!run || wrap);

  // next state and counter
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      IDLE: begin
        if (enable && ch_en
            && (!oneshot || start)) begin
          state_n = RUN;
          cnt_n   = '0;
        end
      end
      RUN: begin
        if (!ch_en) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (wrap) begin
          cnt_n = '0;
          if (oneshot) state_n = IDLE;
        end else if (ce) begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // shadow: later cfg_wr wins pend_valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_p      <= '0;
      act_d      <= '0;
      pend_p     <= '0;
      pend_d     <= '0;
      pend_valid <= 1'b0;
    end else begin
      if (load) begin
        act_p      <= pend_p;
        act_d      <= pend_d;
        pend_valid <= 1'b0;
      end
      if (cfg_wr) begin
        pend_p     <= period;
        pend_d     <= duty;
        pend_valid <= 1'b1;
      end
    end
  end

  // registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pulse <= 1'b0;
      tick  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      pulse <= enable && run && (cnt < act_d);
      tick  <= wrap;
      busy  <= run;
    end
  end

endmodule

// File: rtl/pwm_timer_mc.sv
// pwm_timer_mc: multi-channel PWM/interval timer
// PWM_TIMER_MC_IRQ_EN adds irq_clr/irq_stat/irq
module pwm_timer_mc
  import pwm_timer_pkg::*;
#(
  parameter int NUM_CH  = NUM_CH_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int PRESC_W = PRESC_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic [PRESC_W-1:0]      presc,
  input  logic [NUM_CH-1:0]       ch_en,
  input  logic [NUM_CH-1:0]       mode,
  input  logic [NUM_CH-1:0]       start,
  input  logic                    cfg_wr,
  input  logic [NUM_CH*CNT_W-1:0] period,
  input  logic [NUM_CH*CNT_W-1:0] duty,
`ifdef PWM_TIMER_MC_IRQ_EN
  input  logic [NUM_CH-1:0]       irq_clr,
  output logic [NUM_CH-1:0]       irq_stat,
  output logic                    irq,
`endif
  output logic [NUM_CH-1:0]       pulse,
  output logic [NUM_CH-1:0]       tick,
  output logic [NUM_CH-1:0]       busy
);

  logic [PRESC_W-1:0] pcnt;
  logic               pwrap;
  logic               ce;

  // shrinking presc below pcnt rolls over now
  assign pwrap = (pcnt >= presc);
  assign ce    = enable && pwrap;

  // shared prescaler, holds while disabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt <= '0;
    end else if (enable) begin
      pcnt <= pwrap ? '0 : pcnt + PRESC_W'(1);
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    pwm_timer_ch #(
      .CNT_W (CNT_W)
    ) u_ch (
      .clk    (clk),
      .rst_n  (rst_n),
      .enable (enable),
      .ce     (ce),
      .ch_en  (ch_en[i]),
      .mode   (mode[i]),
      .start  (start[i]),
      .cfg_wr (cfg_wr),
      .period (period[i*CNT_W +: CNT_W]),
      .duty   (duty[i*CNT_W +: CNT_W]),
      .pulse  (pulse[i]),
      .tick   (tick[i]),
      .busy   (busy[i])
    );
  end

`ifdef PWM_TIMER_MC_IRQ_EN
  logic [NUM_CH-1:0] irq_stat_n;

  assign irq_stat_n = (irq_stat & ~irq_clr)
                    | tick;

  // sticky status, set beats clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_stat <= '0;
      irq      <= 1'b0;
    end else begin
      irq_stat <= irq_stat_n;
      irq      <= |irq_stat_n;
    end
  end
`endif

endmodule

// File: tb/tb_pwm_timer_mc.sv
// tb_pwm_timer_mc: directed bench
// for the multi-channel PWM timer
module tb_pwm_timer_mc;

  localparam int NCH = 4;
  localparam int CW  = 16;
  localparam int PW  = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              enable;
  logic [PW-1:0]     presc;
  logic [NCH-1:0]    ch_en;
  logic [NCH-1:0]    mode;
  logic [NCH-1:0]    start;
  logic              cfg_wr;
  logic [NCH*CW-1:0] period;
  logic [NCH*CW-1:0] duty;
  logic [NCH-1:0]    pulse;
  logic [NCH-1:0]    tick;
  logic [NCH-1:0]    busy;
`ifdef PWM_TIMER_MC_IRQ_EN
  logic [NCH-1:0]    irq_clr;
  logic [NCH-1:0]    irq_stat;
  logic              irq;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pwm_timer_mc #(
    .NUM_CH  (NCH),
    .CNT_W   (CW),
    .PRESC_W (PW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .presc    (presc),
    .ch_en    (ch_en),
    .mode     (mode),
    .start    (start),
    .cfg_wr   (cfg_wr),
    .period   (period),
    .duty     (duty),
`ifdef PWM_TIMER_MC_IRQ_EN
    .irq_clr  (irq_clr),
    .irq_stat (irq_stat),
    .irq      (irq),
`endif
    .pulse    (pulse),
    .tick     (tick),
    .busy     (busy)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_ch(input int ch,
                        input int p,
                        input int d);
    period[ch*CW +: CW] = CW'(p);
    duty[ch*CW +: CW]   = CW'(d);
  endtask

  task automatic cfg();
    cfg_wr = 1'b1;
    @(negedge clk);
    cfg_wr = 1'b0;
  endtask

  task automatic wait_tick(input int ch,
                           input int budget,
                           output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tick[ch] && n < budget);
    if (!tick[ch]) n = -1;
  endtask

  task automatic wait_sync(input string tag,
                           input int ch,
                           input int budget);
    int n;
    wait_tick(ch, budget, n);
    chk(tag, 64'(n > 0), 64'd1);
  endtask

  task automatic capture(input int ch,
                         input int n,
                         output logic [63:0] pv,
                         output logic [63:0] tv,
                         output logic [63:0] bv);
    pv = '0;
    tv = '0;
    bv = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      pv[i] = pulse[ch];
      tv[i] = tick[ch];
      bv[i] = busy[ch];
    end
  endtask

  initial begin
    logic [63:0] pv;
    logic [63:0] tv;
    logic [63:0] bv;
    int          n;

    rst_n  = 1'b0;
    enable = 1'b0;
    presc  = '0;
    ch_en  = '0;
    mode   = '0;
    start  = '0;
    cfg_wr = 1'b0;
    period = '0;
    duty   = '0;
`ifdef PWM_TIMER_MC_IRQ_EN
    irq_clr = '0;
`endif
    step(3);
    chk("rst_pulse", 64'(pulse), 64'd0);
    chk("rst_tick", 64'(tick), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
`ifdef PWM_TIMER_MC_IRQ_EN
    chk("rst_irq", 64'({irq, irq_stat}), 64'd0);
`endif
    rst_n = 1'b1;

    // continuous, period 10, duty 5
    enable = 1'b1;
    presc  = '0;
    set_ch(0, 10, 5);
    cfg();
    ch_en[0] = 1'b1;
    step(1);
    chk("busy_lag", 64'(busy[0]), 64'd0);
    step(1);
    chk("busy_on", 64'(busy[0]), 64'd1);
    wait_sync("t1_sync", 0, 30);
    capture(0, 10, pv, tv, bv);
    chk("t1_pulse", pv, 64'h01F);
    chk("t1_tick", tv, 64'h200);
    chk("t1_busy", bv, 64'h3FF);

    // prescaled: presc 3, period 4, duty 1
    ch_en[0] = 1'b0;
    step(2);
    chk("chen_idle", 64'(busy[0]), 64'd0);
    presc = 8'd3;
    set_ch(0, 4, 1);
    cfg();
    ch_en[0] = 1'b1;
    wait_sync("t2_sync", 0, 80);
    capture(0, 16, pv, tv, bv);
    chk("t2_pulse", pv, 64'h000F);
    chk("t2_tick", tv, 64'h8000);

    // one-shot on ch1, period 6, duty 3
    presc   = '0;
    mode[1] = 1'b1;
    set_ch(1, 6, 3);
    cfg();
    ch_en[1] = 1'b1;
    step(2);
    chk("os_wait", 64'(busy[1]), 64'd0);
    for (int r = 0; r < 2; r++) begin
      start[1] = 1'b1;
      step(1);
      start[1] = 1'b0;
      capture(1, 12, pv, tv, bv);
      chk("os_busy", bv, 64'h03F);
      chk("os_pulse", pv, 64'h007);
      chk("os_tick", tv, 64'h020);
      step(4);
      chk("os_idle", 64'({busy[1], pulse[1]}),
          64'd0);
    end

    // shadow update mid-period 10/5 -> 20/2
    set_ch(0, 10, 5);
    cfg();
    wait_sync("t4_sync_a", 0, 40);
    wait_sync("t4_sync_b", 0, 40);
    step(3);
    set_ch(0, 20, 2);
    cfg();
    wait_tick(0, 30, n);
    chk("t4_old_len", 64'(n), 64'd6);
    capture(0, 20, pv, tv, bv);
    chk("t4_pulse", pv, 64'h00003);
    chk("t4_tick", tv, 64'h80000);

    // duty 0
    set_ch(0, 10, 0);
    cfg();
    wait_sync("d0_sync", 0, 40);
    capture(0, 10, pv, tv, bv);
    chk("d0_pulse", pv, 64'h000);
    chk("d0_tick", tv, 64'h200);

    // duty above period
    set_ch(0, 10, 12);
    cfg();
    wait_sync("d12_sync", 0, 40);
    capture(0, 10, pv, tv, bv);
    chk("d12_pulse", pv, 64'h3FF);
    chk("d12_tick", tv, 64'h200);

    // period 0 acts as 1, presc 2
    presc = 8'd2;
    set_ch(0, 0, 1);
    cfg();
    wait_sync("p0_sync", 0, 64);
    capture(0, 9, pv, tv, bv);
    chk("p0_pulse", pv, 64'h1FF);
    chk("p0_tick", tv, 64'h124);

    // enable low at cnt 3 for 7 clk
    presc = '0;
    set_ch(0, 10, 5);
    cfg();
    wait_sync("en_sync_a", 0, 64);
    wait_sync("en_sync_b", 0, 64);
    step(3);
    enable = 1'b0;
    step(7);
    chk("en_pause_pt",
        64'({pulse[0], tick[0]}), 64'd0);
    chk("en_pause_busy", 64'(busy[0]), 64'd1);
    enable = 1'b1;
    capture(0, 7, pv, tv, bv);
    chk("en_res_pulse", pv, 64'h03);
    chk("en_res_tick", tv, 64'h40);

`ifdef PWM_TIMER_MC_IRQ_EN
    step(2);
    irq_clr = '1;
    step(1);
    irq_clr = '0;
    chk("irq_clr_all",
        64'({irq, irq_stat}), 64'd0);
    wait_tick(0, 20, n);
    chk("irq_tick_gap", 64'(n), 64'd7);
    step(1);
    chk("irq_set", 64'({irq, irq_stat[0]}),
        64'd3);
    step(9);
    chk("irq_tick2", 64'(tick[0]), 64'd1);
    irq_clr[0] = 1'b1;
    step(1);
    chk("irq_set_wins", 64'(irq_stat[0]), 64'd1);
    step(1);
    irq_clr[0] = 1'b0;
    chk("irq_cleared",
        64'({irq, irq_stat[0]}), 64'd0);
`endif

    // ch_en low forces idle
    ch_en = '0;
    step(2);
    chk("all_idle",
        64'({busy, pulse}), 64'd0);

    // async reset mid-run
    ch_en[0] = 1'b1;
    wait_sync("ar_sync", 0, 40);
    step(3);
    chk("ar_pre", 64'({busy[0], pulse[0]}),
        64'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_out",
        64'({busy, pulse, tick}), 64'd0);
    step(2);
    chk("ar_hold",
        64'({busy, pulse, tick}), 64'd0);
    rst_n = 1'b1;

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/pwm_timer_mc.md
Name: pwm_timer_mc

Overview:
Multi-channel PWM/interval timer. Successor to the single-channel fixed-parameter timer.
Adds per-channel runtime period and duty, a shared clock prescaler, continuous or one-shot mode, and glitch-free shadow-register updates at period boundaries.
Sits beside peripheral logic as a generic tick/PWM source.

Parameters:
NUM_CH, 4, number of independent channels (1..16)
CNT_W, 16, width of per-channel counter, period and duty
PRESC_W, 8, width of shared prescaler value

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  global run; low pauses prescaler and all channels, forces pulse/tick low
presc  in  PRESC_W  count-enable (ce) every presc+1 clk cycles
ch_en  in  NUM_CH  per-channel enable; low forces channel to IDLE
mode  in  NUM_CH  0 = continuous, 1 = one-shot
start  in  NUM_CH  one-shot trigger, level-sampled, only honoured in IDLE
cfg_wr  in  1  capture period/duty of all channels into pending shadow
period  in  NUM_CH*CNT_W  packed per-channel period in ce units; 0 is treated as 1
duty  in  NUM_CH*CNT_W  packed per-channel high time in ce units
pulse  out  NUM_CH  PWM output, registered
tick  out  NUM_CH  one-clk pulse at period wrap, registered
busy  out  NUM_CH  channel in RUN, registered

Behaviour:
- Reset: pulse, tick and busy are 0. Prescaler count, cnt, active period/duty and pend_valid are 0. All channels are IDLE.
- Prescaler: counts 0..presc while enable=1, holds while enable=0. ce=1 in the clk where count==presc. presc=0 gives ce every clk.
- Per-channel FSM, state IDLE:
  - mode=0 and ch_en=1: go to RUN, cnt=0.
  - mode=1, ch_en=1 and start=1: go to RUN, cnt=0.
- Per-channel FSM, state RUN:
  - On ce: if cnt==P-1 (wrap), cnt becomes 0; else cnt increments.
  - Wrap in one-shot mode: go to IDLE.
  - ch_en=0: go to IDLE, cnt=0.
  - start in RUN is ignored.
- P = max(active_period, 1).
- Outputs each clk:
  - pulse <= enable && RUN && (cnt < active_duty).
  - tick <= ce && RUN && wrap.
  - busy <= RUN.
- Duty limits: duty=0 gives pulse never high; duty>=P gives pulse constant high while running.
- Compares are unsigned CNT_W. The counter never exceeds P-1.
- Shadow update:
  - cfg_wr=1: pend <= inputs, pend_valid <= 1.
  - Active registers load from pend (and pend_valid clears) at wrap, or in any clk while IDLE.
  - cfg_wr coincident with wrap: old pend goes to active, new values go to pend, pend_valid stays 1.
  - A period change never truncates the current period.
- Enable low mid-period: cnt and state frozen, pulse=tick=0. Resumes from the same cnt.
- Mode change during RUN takes effect at the next wrap.
- Async reset mid-operation: all state returns to reset values immediately. No tick is emitted.

Optional Feature:
PWM_TIMER_MC_IRQ_EN
- Defined: adds input irq_clr[NUM_CH] (write-1-to-clear) and outputs irq_stat[NUM_CH] and irq (1 bit).
  - irq_stat bit sets on its channel's tick.
  - Set beats clear in the same clk.
  - irq = |irq_stat, registered.
  - Reset value is 0.
- Undefined: no such ports or logic.

Decomposition:
- Package pwm_timer_pkg holds:
  - ch_state_e enum {IDLE, RUN}
  - ch_mode_e enum {CONT=0, ONESHOT=1}
  - Default parameter constants
- Sub-module pwm_timer_ch holds one channel's FSM, counter and shadow registers, generated NUM_CH times.
- Prescaler and packing stay in the top level.

Test Plan:
- presc=0, ch0 mode=0, period=10, duty=5, cfg_wr then ch_en=1 -> pulse high 5 of every 10 clk; tick every 10 clk; busy=1.
- presc=3, period=4, duty=1 -> tick every 16 clk; pulse high 4 clk per 16.
- ch1 mode=1, period=6, start pulse -> busy 6 ce; exactly one tick; then IDLE with pulse=0; a second start restarts it.
- Mid-period cfg_wr period 10->20, duty 5->2 -> current period finishes at 10; next period is 20 with duty 2; no short or long period in between.
- Edge values: duty=0 -> pulse stays 0. duty=12 with period=10 -> pulse stays 1. period=0 -> tick every ce. enable low for 7 clk at cnt=3 -> resumes at cnt=3.
- With PWM_TIMER_MC_IRQ_EN: tick sets irq_stat[0] and irq=1. irq_clr[0] coincident with a new tick keeps the bit set; a clear alone drops irq next clk.
